alu_sequencer: RTL and testbench
================================

# alu_sequencer

Single-issue operand sequencer wrapped around the 16-bit ALU. It owns a small register file and accepts one instruction at a time over a valid/ready handshake. It reads two source registers and drives the ALU's A/B/FuncCode inputs, then captures C and OverflowFlag and writes the result back. Its output is the architectural state (registers plus a sticky overflow flag) that the rest of the datapath observes.

## Interface
- data_width, 16, operand/result width; must match the ALU instance
- num_regs, 4, register count; index width is $clog2(num_regs) (2 at default)

- clk  in  1  single clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- inst_valid  in  1  instruction offered
- inst_ready  out  1  sequencer can accept
- inst_func  in  4  ALU FuncCode; 4'b1111 = LDI (load immediate)
- inst_rs, inst_rt, inst_rd  in  idx  source A, source B, destination
- inst_imm  in  data_width  immediate, used only by LDI
- alu_A, alu_B  out  data_width  registered operands to ALU
- alu_FuncCode  out  4  registered function code to ALU
- alu_C  in  data_width  ALU result (combinational from alu_A/B/FuncCode)
- alu_OverflowFlag  in  1  ALU overflow
- wb_valid  out  1  one-cycle pulse per retired instruction
- wb_rd  out  idx  destination of the retiring instruction
- wb_data  out  data_width  value written
- overflow_sticky  out  1  set by any retiring ADD/SUB that overflowed
- clear_flags  in  1  synchronous clear of overflow_sticky
- dbg_addr  in  idx  debug read index
- dbg_data  out  data_width  combinational read of regs[dbg_addr]

## Operation
- FSM states: IDLE, EXEC, WB. Reset state is IDLE.
- IDLE: inst_ready=1. On inst_valid, latch the instruction:
  - alu_A<=regs[rs], alu_B<=regs[rt], alu_FuncCode<=func; latch rd, imm and an is_ldi flag.
  - Go to EXEC.
- EXEC: inst_ready=0.
  - result<=is_ldi ? imm : alu_C.
  - ovf<=(func==0000 or 0001) & alu_OverflowFlag & ~is_ldi.
  - Go to WB.
- WB: inst_ready=0. wb_valid=1, wb_rd=rd, wb_data=result.
  - regs[rd]<=result at the end of the cycle.
  - If ovf, overflow_sticky<=1.
  - Go to IDLE.
- inst_valid while inst_ready=0 is ignored. Offered fields need not stay stable outside IDLE.
- All registers are writable; there is no hardwired zero.
- FuncCodes 0010–1110 retire alu_C unchanged. The ALU returns 0 for 1111, but the sequencer substitutes imm for LDI.
- clear_flags: overflow_sticky<=0, unless a WB with ovf=1 occurs in the same cycle; in that case set wins.
- alu_A, alu_B and alu_FuncCode hold their last values outside EXEC.
- wb_rd and wb_data are don't-care while wb_valid=0; they hold their last values.

## Timing
- Reset (reset_n=0 at a rising edge):
  - state=IDLE, all regs=0, alu_A=alu_B=0, alu_FuncCode=0.
  - wb_valid=0, wb_rd=0, wb_data=0, overflow_sticky=0, inst_ready=1 after the edge.
- Reset mid-EXEC or mid-WB aborts the instruction: no wb_valid, and no register or flag update.
- Accept at edge k. EXEC occupies cycle k..k+1 and WB occupies k+1..k+2.
  - wb_valid is high in the cycle after edge k+1.
  - The register update is visible on dbg_data after edge k+2.
  - inst_ready returns high after edge k+2.
- Throughput: one instruction per 3 cycles.
- No hazard exists: the next instruction's operands are read at its accept edge, which is after the prior write-back.
- dbg_data is a combinational read and reflects a write in the cycle after the WB edge.

## Structure
- Shared package alu_pkg:
  - FuncCode localparams (FC_ADD=4'b0000, FC_SUB=4'b0001 … FC_TWOS=4'b1110, FC_LDI=4'b1111).
  - FSM state enum (IDLE, EXEC, WB).
  - DATA_W=16.
- One natural sub-module: alu_regfile.
  - num_regs × data_width, two combinational read ports (rs/rt) plus the debug port.
  - One synchronous write port, synchronous active-low reset to zero.
- The ALU itself is instantiated by the parent, not inside this block.

## Test plan
- Reset: hold reset_n=0 two cycles, then release → all outputs at reset values, inst_ready=1, dbg_data=0 for every index.
- LDI R1=0x7FFF, LDI R2=0x0001, then ADD func=0000 rd=R3, rs=R1, rt=R2 → wb_data=0x8000, overflow_sticky=1, dbg R3=0x8000.
- SUB func=0001, R1=0x0005, R2=0x0007 → wb_data=0xFFFE, sticky unchanged. Then NOT func=0011 on 0x00FF → 0xFF00.
- Backpressure: inst_valid held high continuously with changing fields → exactly one accept per 3 cycles, and only the fields present in IDLE are used.
- clear_flags asserted in the same cycle as an overflowing ADD's WB → sticky stays 1. clear_flags alone on the next cycle → sticky=0.
- Back-to-back dependency: LDI R0=0x1234, then ADD R0=R0+R0 → 0x2468. Assert reset_n=0 during the second instruction's EXEC → no wb_valid, R0=0 after reset.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU sequencer slice: datapath width, the ALU
// function codes the sequencer needs to recognise, and the sequencer FSM
// state type.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W = 16;

    localparam logic [3:0] FC_ADD  = 4'b0000;
    localparam logic [3:0] FC_SUB  = 4'b0001;
    localparam logic [3:0] FC_NOT  = 4'b0011;
    localparam logic [3:0] FC_TWOS = 4'b1110;
    localparam logic [3:0] FC_LDI  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } seq_state_t;

    // Only ADD and SUB are allowed to raise the architectural overflow flag;
    // the ALU may report overflow for other codes but it is not meaningful.
    function automatic logic is_arith(input logic [3:0] func);
        return (func == FC_ADD) || (func == FC_SUB);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// -----------------------------------------------------------------------------
// alu_regfile
// num_regs x data_width register file for the ALU sequencer.
//   clk      : rising-edge clock
//   reset_n  : synchronous active-low reset, clears every register to zero
//   rs_addr  : read port A index      -> rs_data (combinational)
//   rt_addr  : read port B index      -> rt_data (combinational)
//   dbg_addr : debug read index       -> dbg_data (combinational)
//   we       : write enable
//   wr_addr  : write index
//   wr_data  : write value, stored at the rising edge when we=1
// Reset takes priority over a same-cycle write.
// -----------------------------------------------------------------------------
module alu_regfile
    import alu_pkg::*;
#(
    parameter int data_width = DATA_W,
    parameter int num_regs   = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [$clog2(num_regs)-1:0] rs_addr,
    input  logic [$clog2(num_regs)-1:0] rt_addr,
    input  logic [$clog2(num_regs)-1:0] dbg_addr,
    output logic [data_width-1:0]       rs_data,
    output logic [data_width-1:0]       rt_data,
    output logic [data_width-1:0]       dbg_data,
    input  logic                        we,
    input  logic [$clog2(num_regs)-1:0] wr_addr,
    input  logic [data_width-1:0]       wr_data
);

    logic [data_width-1:0] regs [num_regs];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < num_regs; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rs_data  = regs[rs_addr];
    assign rt_data  = regs[rt_addr];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Single-issue operand sequencer around an external 16-bit ALU. Accepts one
// instruction per three cycles (IDLE -> EXEC -> WB), reads two source
// registers into the ALU operand registers, captures the ALU result (or the
// immediate for LDI) and writes it back, maintaining a sticky overflow flag.
//   clk, reset_n        : clock, synchronous active-low reset
//   inst_valid/ready    : instruction handshake (ready only in IDLE)
//   inst_func           : ALU FuncCode, 4'b1111 = LDI
//   inst_rs/rt/rd       : source A, source B, destination indices
//   inst_imm            : LDI immediate
//   alu_A/B/FuncCode    : registered ALU inputs
//   alu_C/OverflowFlag  : ALU result and overflow (combinational from inputs)
//   wb_valid/rd/data    : one-cycle retire pulse with destination and value
//   overflow_sticky     : set by any retiring ADD/SUB that overflowed
//   clear_flags         : synchronous clear of overflow_sticky (set wins)
//   dbg_addr/dbg_data   : combinational debug read of the register file
// -----------------------------------------------------------------------------
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int data_width = DATA_W,
    parameter int num_regs   = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        inst_valid,
    output logic                        inst_ready,
    input  logic [3:0]                  inst_func,
    input  logic [$clog2(num_regs)-1:0] inst_rs,
    input  logic [$clog2(num_regs)-1:0] inst_rt,
    input  logic [$clog2(num_regs)-1:0] inst_rd,
    input  logic [data_width-1:0]       inst_imm,
    output logic [data_width-1:0]       alu_A,
    output logic [data_width-1:0]       alu_B,
    output logic [3:0]                  alu_FuncCode,
    input  logic [data_width-1:0]       alu_C,
    input  logic                        alu_OverflowFlag,
    output logic                        wb_valid,
    output logic [$clog2(num_regs)-1:0] wb_rd,
    output logic [data_width-1:0]       wb_data,
    output logic                        overflow_sticky,
    input  logic                        clear_flags,
    input  logic [$clog2(num_regs)-1:0] dbg_addr,
    output logic [data_width-1:0]       dbg_data
);

    localparam int idx_w = $clog2(num_regs);

    seq_state_t            state;
    seq_state_t            state_next;
    logic                  accept;
    logic [data_width-1:0] rs_data;
    logic [data_width-1:0] rt_data;
    logic [idx_w-1:0]      rd_q;
    logic [data_width-1:0] imm_q;
    logic                  is_ldi_q;
    logic                  ovf_q;

    alu_regfile #(
        .data_width (data_width),
        .num_regs   (num_regs)
    ) u_regfile (
        .clk      (clk),
        .reset_n  (reset_n),
        .rs_addr  (inst_rs),
        .rt_addr  (inst_rt),
        .dbg_addr (dbg_addr),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .dbg_data (dbg_data),
        .we       (wb_valid),
        .wr_addr  (wb_rd),
        .wr_data  (wb_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake/retire outputs
    always_comb begin
        state_next = state;
        inst_ready = 1'b0;
        wb_valid   = 1'b0;
        case (state)
            IDLE: begin
                inst_ready = 1'b1;
                if (inst_valid) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = WB;
            end
            WB: begin
                wb_valid   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign accept = inst_valid & inst_ready;

    // Issue stage: operands are read at the accept edge, which is always after
    // the previous write-back, so there is no read-after-write hazard.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            alu_A        <= '0;
            alu_B        <= '0;
            alu_FuncCode <= '0;
            rd_q         <= '0;
            imm_q        <= '0;
            is_ldi_q     <= 1'b0;
        end else if (accept) begin
            alu_A        <= rs_data;
            alu_B        <= rt_data;
            alu_FuncCode <= inst_func;
            rd_q         <= inst_rd;
            imm_q        <= inst_imm;
            is_ldi_q     <= (inst_func == FC_LDI);
        end
    end

    // Execute stage: the result register doubles as wb_data, so it holds its
    // value until the next instruction reaches EXEC.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wb_rd   <= '0;
            wb_data <= '0;
            ovf_q   <= 1'b0;
        end else if (state == EXEC) begin
            wb_rd   <= rd_q;
            wb_data <= is_ldi_q ? imm_q : alu_C;
            ovf_q   <= is_arith(alu_FuncCode) & alu_OverflowFlag & ~is_ldi_q;
        end
    end

    // Write-back: a retiring overflow beats a same-cycle clear request
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow_sticky <= 1'b0;
        end else if (wb_valid && ovf_q) begin
            overflow_sticky <= 1'b1;
        end else if (clear_flags) begin
            overflow_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
// Self-checking bench for alu_sequencer. Provides a behavioural 16-bit ALU on
// the alu_* ports, keeps a transaction-level model of the architectural state
// (registers, sticky flag, one in-flight instruction with a cycle countdown),
// compares the DUT against it every cycle, and adds literal checks for the
// directed scenarios.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

    localparam logic [3:0] F_ADD = 4'h0;
    localparam logic [3:0] F_SUB = 4'h1;
    localparam logic [3:0] F_NOT = 4'h3;
    localparam logic [3:0] F_SHL = 4'h6;
    localparam logic [3:0] F_LDI = 4'hF;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        inst_valid;
    logic        inst_ready;
    logic [3:0]  inst_func;
    logic [1:0]  inst_rs, inst_rt, inst_rd;
    logic [15:0] inst_imm;
    logic [15:0] alu_A, alu_B;
    logic [3:0]  alu_FuncCode;
    logic [15:0] alu_C;
    logic        alu_OverflowFlag;
    logic        wb_valid;
    logic [1:0]  wb_rd;
    logic [15:0] wb_data;
    logic        overflow_sticky;
    logic        clear_flags;
    logic [1:0]  dbg_addr;
    logic [15:0] dbg_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.data_width(16), .num_regs(4)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .inst_func        (inst_func),
        .inst_rs          (inst_rs),
        .inst_rt          (inst_rt),
        .inst_rd          (inst_rd),
        .inst_imm         (inst_imm),
        .alu_A            (alu_A),
        .alu_B            (alu_B),
        .alu_FuncCode     (alu_FuncCode),
        .alu_C            (alu_C),
        .alu_OverflowFlag (alu_OverflowFlag),
        .wb_valid         (wb_valid),
        .wb_rd            (wb_rd),
        .wb_data          (wb_data),
        .overflow_sticky  (overflow_sticky),
        .clear_flags      (clear_flags),
        .dbg_addr         (dbg_addr),
        .dbg_data         (dbg_data)
    );

    // Behavioural ALU: returns {overflow, result}. Shift-left also reports an
    // overflow so the sequencer's ADD/SUB-only masking is exercised.
    function automatic logic [16:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] f);
        logic [15:0] c;
        logic        o;
        o = 1'b0;
        case (f)
            4'h0: begin c = a + b; o = (a[15] == b[15]) && (c[15] != a[15]); end
            4'h1: begin c = a - b; o = (a[15] != b[15]) && (c[15] != a[15]); end
            4'h2: c = a & b;
            4'h3: c = ~a;
            4'h4: c = a | b;
            4'h5: c = a ^ b;
            4'h6: begin c = a << 1; o = a[15] ^ a[14]; end
            4'h7: c = a >> 1;
            4'hE: begin c = -a; o = (a == 16'h8000); end
            4'hF: c = 16'h0000;
            default: begin c = a + b + {12'h000, f}; o = a[0]; end
        endcase
        return {o, c};
    endfunction

    assign {alu_OverflowFlag, alu_C} = alu_f(alu_A, alu_B, alu_FuncCode);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_regs [4];
    bit          m_sticky;
    int          m_cnt;       // 0 = can accept, 2 = executing, 1 = retiring
    logic [15:0] m_res;
    logic [1:0]  m_rd;
    bit          m_ovf;
    logic [15:0] e_A, e_B;
    logic [3:0]  e_F;
    logic [1:0]  e_wb_rd;
    logic [15:0] e_wb_data;
    bit          model_ok = 0;

    always @(posedge clk) begin
        logic [16:0] r;
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) m_regs[i] = 16'h0;
            m_sticky  = 0;
            m_cnt     = 0;
            m_ovf     = 0;
            e_A       = 16'h0;
            e_B       = 16'h0;
            e_F       = 4'h0;
            e_wb_rd   = 2'd0;
            e_wb_data = 16'h0;
            model_ok  = 1;
        end else begin
            if (m_cnt == 1) m_regs[m_rd] = m_res;
            if (m_cnt == 1 && m_ovf) m_sticky = 1;
            else if (clear_flags)    m_sticky = 0;
            if (m_cnt == 0) begin
                if (inst_valid) begin
                    e_A   = m_regs[inst_rs];
                    e_B   = m_regs[inst_rt];
                    e_F   = inst_func;
                    r     = alu_f(e_A, e_B, inst_func);
                    m_res = (inst_func == F_LDI) ? inst_imm : r[15:0];
                    m_ovf = (inst_func == F_ADD || inst_func == F_SUB) && r[16];
                    m_rd  = inst_rd;
                    m_cnt = 2;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 1) begin
                    e_wb_rd   = m_rd;
                    e_wb_data = m_res;
                end
            end
        end
    end

    // Every-cycle compare, away from the active edge
    always @(negedge clk) begin
        if (model_ok) begin
            chk("inst_ready", inst_ready, m_cnt == 0);
            chk("wb_valid", wb_valid, m_cnt == 1);
            chk("overflow_sticky", overflow_sticky, m_sticky);
            chk("alu_A", alu_A, e_A);
            chk("alu_B", alu_B, e_B);
            chk("alu_FuncCode", alu_FuncCode, e_F);
            chk("dbg_data", dbg_data, m_regs[dbg_addr]);
            if (m_cnt == 1) begin
                chk("wb_rd", wb_rd, e_wb_rd);
                chk("wb_data", wb_data, e_wb_data);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_fields();
        inst_func = 4'($urandom);
        inst_rs   = 2'($urandom);
        inst_rt   = 2'($urandom);
        inst_rd   = 2'($urandom);
        case ($urandom_range(0, 4))
            0: inst_imm = 16'h7FFF;
            1: inst_imm = 16'h8000;
            2: inst_imm = 16'hFFFF;
            3: inst_imm = 16'h0001;
            default: inst_imm = 16'($urandom);
        endcase
    endtask

    // Issue one instruction from IDLE and run it to completion; wbv/wbd are
    // sampled in the retire cycle. clr_wb raises clear_flags in that cycle.
    task automatic issue(input logic [3:0] f, input logic [1:0] rs, input logic [1:0] rt,
                         input logic [1:0] rd, input logic [15:0] imm, input bit clr_wb,
                         output logic wbv, output logic [15:0] wbd);
        inst_valid = 1'b1;
        inst_func  = f;
        inst_rs    = rs;
        inst_rt    = rt;
        inst_rd    = rd;
        inst_imm   = imm;
        step();
        inst_valid = 1'b0;
        rand_fields();
        step();
        clear_flags = clr_wb;
        wbv = wb_valid;
        wbd = wb_data;
        step();
        clear_flags = 1'b0;
    endtask

    task automatic ldi(input logic [1:0] rd, input logic [15:0] imm);
        logic        v;
        logic [15:0] d;
        issue(F_LDI, 2'd0, 2'd0, rd, imm, 1'b0, v, d);
    endtask

    task automatic dbg_chk(input string nm, input logic [1:0] a, input logic [15:0] exp);
        dbg_addr = a;
        #1;
        chk(nm, dbg_data, exp);
    endtask

    initial begin
        logic        v;
        logic [15:0] d;
        int          acc;

        reset_n     = 1'b0;
        inst_valid  = 1'b0;
        clear_flags = 1'b0;
        inst_func   = 4'h0;
        inst_rs     = 2'd0;
        inst_rt     = 2'd0;
        inst_rd     = 2'd0;
        inst_imm    = 16'h0;
        dbg_addr    = 2'd0;

        // Reset state
        step();
        step();
        reset_n = 1'b1;
        chk("rst_ready", inst_ready, 1'b1);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_rd", wb_rd, 2'd0);
        chk("rst_wb_data", wb_data, 16'h0);
        chk("rst_sticky", overflow_sticky, 1'b0);
        chk("rst_alu_A", alu_A, 16'h0);
        chk("rst_alu_B", alu_B, 16'h0);
        chk("rst_alu_F", alu_FuncCode, 4'h0);
        for (int i = 0; i < 4; i++) dbg_chk("rst_dbg", 2'(i), 16'h0);

        // ADD overflow
        ldi(2'd1, 16'h7FFF);
        ldi(2'd2, 16'h0001);
        issue(F_ADD, 2'd1, 2'd2, 2'd3, 16'h0, 1'b0, v, d);
        chk("add_wb_valid", v, 1'b1);
        chk("add_wb_data", d, 16'h8000);
        chk("add_sticky", overflow_sticky, 1'b1);
        dbg_chk("add_dbg_r3", 2'd3, 16'h8000);

        // SUB without overflow, then NOT
        ldi(2'd1, 16'h0005);
        ldi(2'd2, 16'h0007);
        issue(F_SUB, 2'd1, 2'd2, 2'd0, 16'h0, 1'b0, v, d);
        chk("sub_wb_data", d, 16'hFFFE);
        chk("sub_sticky", overflow_sticky, 1'b1);
        ldi(2'd1, 16'h00FF);
        issue(F_NOT, 2'd1, 2'd0, 2'd2, 16'h0, 1'b0, v, d);
        chk("not_wb_data", d, 16'hFF00);
        dbg_chk("not_dbg_r2", 2'd2, 16'hFF00);

        // clear alone, then non-arith code with ALU overflow does not set sticky
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        chk("clr_sticky", overflow_sticky, 1'b0);
        ldi(2'd1, 16'h4000);
        issue(F_SHL, 2'd1, 2'd0, 2'd1, 16'h0, 1'b0, v, d);
        chk("shl_wb_data", d, 16'h8000);
        chk("shl_sticky", overflow_sticky, 1'b0);

        // clear_flags coincident with an overflowing retire: set wins
        ldi(2'd1, 16'h7FFF);
        ldi(2'd2, 16'h0001);
        issue(F_ADD, 2'd1, 2'd2, 2'd3, 16'h0, 1'b1, v, d);
        chk("setwins_sticky", overflow_sticky, 1'b1);
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        chk("clr_after_sticky", overflow_sticky, 1'b0);

        // Backpressure: valid held high with fields changing every cycle
        acc = 0;
        inst_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            rand_fields();
            if (inst_ready) acc++;
            step();
        end
        inst_valid = 1'b0;
        step();
        step();
        step();
        chk("bp_accepts", acc, 10);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rand_fields();
            case ($urandom_range(0, 3))
                0: inst_func = F_LDI;
                1: inst_func = 4'($urandom_range(0, 1));
                default: ;
            endcase
            inst_valid  = ($urandom_range(0, 3) != 0);
            clear_flags = ($urandom_range(0, 7) == 0);
            dbg_addr    = 2'($urandom);
            step();
        end
        inst_valid  = 1'b0;
        clear_flags = 1'b0;
        step();
        step();
        step();

        // Back-to-back dependency, then reset during EXEC
        ldi(2'd0, 16'h1234);
        issue(F_ADD, 2'd0, 2'd0, 2'd0, 16'h0, 1'b0, v, d);
        chk("dep_wb_data", d, 16'h2468);
        dbg_chk("dep_dbg_r0", 2'd0, 16'h2468);
        inst_valid = 1'b1;
        inst_func  = F_ADD;
        inst_rs    = 2'd0;
        inst_rt    = 2'd0;
        inst_rd    = 2'd0;
        step();
        inst_valid = 1'b0;
        reset_n    = 1'b0;
        step();
        reset_n = 1'b1;
        chk("rexec_wb_valid0", wb_valid, 1'b0);
        step();
        chk("rexec_wb_valid1", wb_valid, 1'b0);
        dbg_chk("rexec_dbg_r0", 2'd0, 16'h0);

        // Reset during WB: no register update survives
        ldi(2'd1, 16'h7FFF);
        inst_valid = 1'b1;
        inst_func  = F_ADD;
        inst_rs    = 2'd1;
        inst_rt    = 2'd1;
        inst_rd    = 2'd1;
        step();
        inst_valid = 1'b0;
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        dbg_chk("rwb_dbg_r1", 2'd1, 16'h0);
        chk("rwb_sticky", overflow_sticky, 1'b0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
